// File: rtl/opp_packet_rx.sv
// Receive framer for 6-byte opponent-state packets arriving on a byte-wide AXI stream.
// Validates length, XOR checksum and field ranges, then registers the opponent state.
module opp_packet_rx #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ALIVE_CYCLES   = 1048576,
    parameter int INIT_X         = 300,
    parameter int INIT_Y         = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        axiiv,
    input  logic [7:0]  axiid,
    input  logic        axiil,
    output logic [10:0] r_opp_x,
    output logic [10:0] r_opp_y,
    output logic [8:0]  r_opp_dir,
    output logic [2:0]  r_opp_game,
    output logic        receive_axiov,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [15:0] good_count,
    output logic [15:0] bad_count,
    output logic        link_alive
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(ALIVE_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
    localparam logic [AW-1:0] ALIVE_LAST  = AW'(ALIVE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;
    typedef enum logic [1:0] {
        E_CKSUM   = 2'd0,
        E_LEN     = 2'd1,
        E_TIMEOUT = 2'd2,
        E_RANGE   = 2'd3
    } err_t;

    state_t        r_state, w_next_state;
    logic [7:0]    r_buf [0:4];
    logic [2:0]    r_idx;
    logic [TW-1:0] r_idle;
    logic [AW-1:0] r_alive_cnt;

    logic          w_timeout, w_first, w_store, w_good, w_bad, w_range_bad;
    err_t          w_err;
    logic [7:0]    w_cksum;
    logic [10:0]   w_x, w_y;
    logic [8:0]    w_dir;
    logic [2:0]    w_game;

    assign w_timeout   = (r_state == S_COLLECT) && (r_idle == TIMEOUT_VAL);
    // A byte landing on the timeout cycle opens a fresh packet.
    assign w_first     = axiiv && ((r_state == S_IDLE) || w_timeout);
    assign w_store     = axiiv && (r_state == S_COLLECT) && !w_timeout && (r_idx < 3'd5);
    assign w_cksum     = r_buf[0] ^ r_buf[1] ^ r_buf[2] ^ r_buf[3] ^ r_buf[4] ^ axiid;
    assign {w_x, w_y, w_dir, w_game} = {r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4][7:6]};
    assign w_range_bad = (w_dir > 9'd359) || (w_game > 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_next_state = r_state;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        w_err        = E_CKSUM;
        case (r_state)
            S_IDLE: begin
                if (axiiv) begin
                    if (axiil) begin
                        w_bad = 1'b1;
                        w_err = E_LEN;
                    end else begin
                        w_next_state = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (w_timeout) begin
                    w_bad        = 1'b1;
                    w_err        = E_TIMEOUT;
                    w_next_state = (axiiv && !axiil) ? S_COLLECT : S_IDLE;
                end else if (axiiv) begin
                    if (r_idx == 3'd5) begin
                        if (axiil) begin
                            w_next_state = S_IDLE;
                            if (w_cksum != 8'h00) begin
                                w_bad = 1'b1;
                                w_err = E_CKSUM;
                            end else if (w_range_bad) begin
                                w_bad = 1'b1;
                                w_err = E_RANGE;
                            end else begin
                                w_good = 1'b1;
                            end
                        end else begin
                            w_bad        = 1'b1;
                            w_err        = E_LEN;
                            w_next_state = S_DRAIN;
                        end
                    end else if (axiil) begin
                        w_bad        = 1'b1;
                        w_err        = E_LEN;
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (axiiv && axiil) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: the payload buffer is pure data qualified by the FSM, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_first) begin
            r_buf[0] <= axiid;
        end else if (w_store) begin
            r_buf[r_idx] <= axiid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= 3'd0;
            r_idle <= '0;
        end else begin
            if (w_first) begin
                r_idx <= 3'd1;
            end else if (w_store) begin
                r_idx <= r_idx + 3'd1;
            end
            if (axiiv || (w_next_state != S_COLLECT)) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opp_x       <= 11'(INIT_X);
            r_opp_y       <= 11'(INIT_Y);
            r_opp_dir     <= 9'd0;
            r_opp_game    <= 3'd0;
            receive_axiov <= 1'b0;
            err_pulse     <= 1'b0;
            err_code      <= 2'd0;
            good_count    <= 16'd0;
            bad_count     <= 16'd0;
            link_alive    <= 1'b0;
            r_alive_cnt   <= '0;
        end else begin
            receive_axiov <= w_good;
            err_pulse     <= w_bad;
            if (w_good) begin
                r_opp_x    <= w_x;
                r_opp_y    <= w_y;
                r_opp_dir  <= w_dir;
                r_opp_game <= w_game;
                if (good_count != 16'hFFFF) begin
                    good_count <= good_count + 16'd1;
                end
            end
            if (w_bad) begin
                err_code <= w_err;
                if (bad_count != 16'hFFFF) begin
                    bad_count <= bad_count + 16'd1;
                end
            end
            if (w_good) begin
                link_alive  <= 1'b1;
                r_alive_cnt <= '0;
            end else if (link_alive) begin
                if (r_alive_cnt == ALIVE_LAST) begin
                    link_alive <= 1'b0;
                end
                r_alive_cnt <= r_alive_cnt + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_opp_packet_rx.sv
// Self-checking bench for opp_packet_rx: directed scenarios with literal expectations,
// then randomized frames compared every cycle against a frame-level reference model.
module tb_opp_packet_rx;
    localparam int TB_TIMEOUT = 1024;
    localparam int TB_ALIVE   = 3000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        axiiv = 1'b0;
    logic [7:0]  axiid = 8'h00;
    logic        axiil = 1'b0;
    logic [10:0] r_opp_x, r_opp_y;
    logic [8:0]  r_opp_dir;
    logic [2:0]  r_opp_game;
    logic        receive_axiov, err_pulse, link_alive;
    logic [1:0]  err_code;
    logic [15:0] good_count, bad_count;

    always #5 clk = ~clk;

    opp_packet_rx #(
        .TIMEOUT_CYCLES(TB_TIMEOUT),
        .ALIVE_CYCLES  (TB_ALIVE),
        .INIT_X        (300),
        .INIT_Y        (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axiiv        (axiiv),
        .axiid        (axiid),
        .axiil        (axiil),
        .r_opp_x      (r_opp_x),
        .r_opp_y      (r_opp_y),
        .r_opp_dir    (r_opp_dir),
        .r_opp_game   (r_opp_game),
        .receive_axiov(receive_axiov),
        .err_pulse    (err_pulse),
        .err_code     (err_code),
        .good_count   (good_count),
        .bad_count    (bad_count),
        .link_alive   (link_alive)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (frame level, timestamp based) ----------------
    typedef enum int {EV_NONE, EV_GOOD, EV_CKS, EV_LEN, EV_TO, EV_RANGE} ev_t;

    ev_t         ev;
    int          m_cyc, m_last_byte, m_last_good, m_n;
    bit          m_open, m_drain, m_have_good;
    logic [7:0]  m_pkt [0:5];
    logic [39:0] m_word;

    logic [10:0] exp_x = 11'd300, exp_y = 11'd100;
    logic [8:0]  exp_dir = 9'd0;
    logic [2:0]  exp_game = 3'd0;
    logic        exp_rx = 1'b0, exp_err = 1'b0, exp_alive = 1'b0;
    logic [1:0]  exp_code = 2'd0;
    logic [15:0] exp_good = 16'd0, exp_bad = 16'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_last_byte = 0; m_last_good = 0; m_n = 0;
            m_open = 0; m_drain = 0; m_have_good = 0;
            exp_x = 11'd300; exp_y = 11'd100; exp_dir = 9'd0; exp_game = 3'd0;
            exp_rx = 0; exp_err = 0; exp_code = 0; exp_good = 0; exp_bad = 0; exp_alive = 0;
        end else begin
            m_cyc++;
            ev = EV_NONE;
            if (m_open && (m_cyc - m_last_byte == TB_TIMEOUT + 1)) begin
                ev = EV_TO;
                m_open = 0;
            end
            if (axiiv) begin
                if (m_drain) begin
                    if (axiil) m_drain = 0;
                end else if (!m_open) begin
                    if (axiil) begin
                        if (ev == EV_NONE) ev = EV_LEN;
                    end else begin
                        m_open = 1; m_n = 1; m_pkt[0] = axiid; m_last_byte = m_cyc;
                    end
                end else begin
                    m_pkt[m_n] = axiid;
                    m_n++;
                    m_last_byte = m_cyc;
                    if (m_n == 6) begin
                        m_open = 0;
                        if (!axiil) begin
                            ev = EV_LEN;
                            m_drain = 1;
                        end else begin
                            m_word = {m_pkt[0], m_pkt[1], m_pkt[2], m_pkt[3], m_pkt[4]};
                            if ((m_pkt[0] ^ m_pkt[1] ^ m_pkt[2] ^ m_pkt[3] ^ m_pkt[4] ^ m_pkt[5]) != 8'h00)
                                ev = EV_CKS;
                            else if (m_word[17:9] > 9'd359 || m_word[8:6] > 3'd2)
                                ev = EV_RANGE;
                            else
                                ev = EV_GOOD;
                        end
                    end else if (axiil) begin
                        ev = EV_LEN;
                        m_open = 0;
                    end
                end
            end
            exp_rx  = (ev == EV_GOOD);
            exp_err = (ev != EV_NONE) && (ev != EV_GOOD);
            if (ev == EV_GOOD) begin
                exp_x    = m_word[39:29];
                exp_y    = m_word[28:18];
                exp_dir  = m_word[17:9];
                exp_game = m_word[8:6];
                if (exp_good != 16'hFFFF) exp_good++;
                m_have_good = 1;
                m_last_good = m_cyc;
            end
            if (exp_err) begin
                case (ev)
                    EV_CKS:  exp_code = 2'd0;
                    EV_LEN:  exp_code = 2'd1;
                    EV_TO:   exp_code = 2'd2;
                    default: exp_code = 2'd3;
                endcase
                if (exp_bad != 16'hFFFF) exp_bad++;
            end
            exp_alive = m_have_good && ((m_cyc - m_last_good) < TB_ALIVE);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("x", r_opp_x, exp_x);
        check("y", r_opp_y, exp_y);
        check("dir", r_opp_dir, exp_dir);
        check("game", r_opp_game, exp_game);
        check("rx_strobe", receive_axiov, exp_rx);
        check("err_strobe", err_pulse, exp_err);
        check("err_code", err_code, exp_code);
        check("good_count", good_count, exp_good);
        check("bad_count", bad_count, exp_bad);
        check("link_alive", link_alive, exp_alive);
        check("strobe_excl", receive_axiov & err_pulse, 0);
    end

    // ---------------- stimulus ----------------
    logic [7:0] frame_buf [0:15];

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        axiiv = 1'b1;
        axiid = b;
        axiil = last;
        @(posedge clk);
        #1;
        axiiv = 1'b0;
        axiil = 1'b0;
        axiid = 8'($urandom);
    endtask

    task automatic send_frame(input int n, input int gap_max, input bit with_last);
        for (int i = 0; i < n; i++) begin
            send_byte(frame_buf[i], with_last && (i == n - 1));
            if (i < n - 1) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic make_pkt(input int x, input int y, input int dir, input int game);
        logic [39:0] w;
        w = {11'(x), 11'(y), 9'(dir), 3'(game), 6'($urandom)};
        for (int i = 0; i < 5; i++) frame_buf[i] = w[39-8*i -: 8];
        frame_buf[5] = frame_buf[0] ^ frame_buf[1] ^ frame_buf[2] ^ frame_buf[3] ^ frame_buf[4];
    endtask

    task automatic random_frame();
        int kind;
        int n;
        kind = $urandom_range(0, 9);
        idle($urandom_range(0, 4));
        case (kind)
            5: begin
                make_pkt($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 359), $urandom_range(0, 2));
                frame_buf[5] = frame_buf[5] ^ 8'($urandom_range(1, 255));
                send_frame(6, 3, 1);
            end
            6: begin
                n = $urandom_range(1, 5);
                for (int i = 0; i < n; i++) frame_buf[i] = 8'($urandom);
                send_frame(n, 3, 1);
            end
            7: begin
                n = $urandom_range(7, 10);
                for (int i = 0; i < n; i++) frame_buf[i] = 8'($urandom);
                send_frame(n, 3, 1);
            end
            8: begin
                if ($urandom_range(0, 1) == 0)
                    make_pkt($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(360, 511), $urandom_range(0, 2));
                else
                    make_pkt($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 359), $urandom_range(3, 7));
                send_frame(6, 3, 1);
            end
            9: begin
                n = $urandom_range(1, 5);
                for (int i = 0; i < n; i++) frame_buf[i] = 8'($urandom);
                send_frame(n, 3, 0);
                idle(TB_TIMEOUT + $urandom_range(0, 2));
            end
            default: begin
                make_pkt($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 359), $urandom_range(0, 2));
                send_frame(6, 3, 1);
            end
        endcase
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", r_opp_x, 300);
        check("rst_y", r_opp_y, 100);
        check("rst_dir", r_opp_dir, 0);
        check("rst_game", r_opp_game, 0);
        check("rst_counts", {good_count, bad_count}, 0);
        check("rst_strobes", {receive_axiov, err_pulse, link_alive}, 0);
        rst_n = 1'b1;
        idle(2);

        // Reference good packet from literal bytes.
        frame_buf[0] = 8'h25; frame_buf[1] = 8'h81; frame_buf[2] = 8'h90;
        frame_buf[3] = 8'hB4; frame_buf[4] = 8'h40; frame_buf[5] = 8'hC0;
        send_frame(6, 0, 1);
        check("good_rx", receive_axiov, 1);
        check("good_x", r_opp_x, 300);
        check("good_y", r_opp_y, 100);
        check("good_dir", r_opp_dir, 90);
        check("good_game", r_opp_game, 1);
        check("good_count1", good_count, 1);
        check("good_link", link_alive, 1);
        idle(1);
        check("good_rx_one_cycle", receive_axiov, 0);

        frame_buf[5] = 8'hC1;
        send_frame(6, 0, 1);
        check("cks_err", err_pulse, 1);
        check("cks_code", err_code, 0);
        check("cks_rx", receive_axiov, 0);
        check("cks_dir_hold", r_opp_dir, 90);
        check("cks_bad1", bad_count, 1);
        idle(2);

        send_frame(4, 0, 1);
        check("short_err", err_pulse, 1);
        check("short_code", err_code, 1);
        idle(2);

        for (int i = 6; i < 8; i++) frame_buf[i] = 8'($urandom);
        send_frame(8, 0, 1);
        idle(2);
        check("long_bad3", bad_count, 3);
        make_pkt(500, 200, 180, 2);
        send_frame(6, 1, 1);
        check("after_long_rx", receive_axiov, 1);
        check("after_long_x", r_opp_x, 500);
        check("after_long_good2", good_count, 2);
        idle(2);

        for (int i = 0; i < 3; i++) frame_buf[i] = 8'($urandom);
        send_frame(3, 0, 0);
        idle(TB_TIMEOUT);
        check("to_not_early", err_pulse, 0);
        idle(1);
        check("to_err", err_pulse, 1);
        check("to_code", err_code, 2);
        check("to_bad4", bad_count, 4);
        make_pkt(300, 100, 90, 1);
        send_frame(6, 0, 1);
        check("after_to_rx", receive_axiov, 1);
        check("after_to_dir", r_opp_dir, 90);
        idle(2);

        make_pkt(300, 100, 360, 1);
        send_frame(6, 0, 1);
        check("range_err", err_pulse, 1);
        check("range_code", err_code, 3);
        check("range_dir_hold", r_opp_dir, 90);
        idle(2);

        repeat (150) random_frame();
        idle(6);

        // Reset in the middle of a packet.
        make_pkt(7, 8, 9, 2);
        send_frame(2, 0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pos", {r_opp_x, r_opp_y}, {11'd300, 11'd100});
        check("mid_rst_dir_game", {r_opp_dir, r_opp_game}, 0);
        check("mid_rst_strobes", {receive_axiov, err_pulse, link_alive}, 0);
        idle(1);
        check("mid_rst_no_strobe", {receive_axiov, err_pulse}, 0);
        rst_n = 1'b1;
        idle(2);

        // Link loss after the last good packet.
        make_pkt(100, 50, 10, 0);
        send_frame(6, 0, 1);
        check("final_rx", receive_axiov, 1);
        check("final_good1", good_count, 1);
        k = 0;
        while (link_alive === 1'b1 && k < TB_ALIVE + 10) begin
            idle(1);
            k++;
        end
        check("link_fall_cycles", k, TB_ALIVE);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
